// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU among NREQ valid/ready requesters,
// with a single registered response slot. Optional per-requester grant counters: ALU_ARB_CNT_EN.
module alu_share_arb #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int OPW  = 4,
  parameter int IDW  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req_valid,
  output logic [NREQ-1:0]     o_req_ready,
  input  logic [NREQ*DW-1:0]  i_req_operand_a,
  input  logic [NREQ*DW-1:0]  i_req_operand_b,
  input  logic [NREQ*OPW-1:0] i_req_alu_op,
  output logic [DW-1:0]       o_alu_operand_a,
  output logic [DW-1:0]       o_alu_operand_b,
  output logic [OPW-1:0]      o_alu_op,
  input  logic [DW-1:0]       i_alu_res,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DW-1:0]       o_rsp_data,
  output logic [IDW-1:0]      o_rsp_id,
  output logic                o_busy
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [NREQ*16-1:0]  o_grant_cnt
`endif
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic           slot_free;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] last_grant;

  // The slot can take a new result when empty or when its current one leaves this cycle.
  assign slot_free = !i_rst && ((state_q == S_EMPTY) || i_rsp_ready);

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    int cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_grant) + i) % NREQ;
      if (slot_free && !grant_vld && i_req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  always_comb begin
    o_req_ready     = '0;
    o_alu_operand_a = '0;
    o_alu_operand_b = '0;
    o_alu_op        = '0;
    if (grant_vld) begin
      o_req_ready     = NREQ'(1) << grant_idx;
      o_alu_operand_a = i_req_operand_a[int'(grant_idx)*DW +: DW];
      o_alu_operand_b = i_req_operand_b[int'(grant_idx)*DW +: DW];
      o_alu_op        = i_req_alu_op[int'(grant_idx)*OPW +: OPW];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (grant_vld) state_d = S_FULL;
      S_FULL:  if (!grant_vld && i_rsp_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_data <= '0;
      o_rsp_id   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (grant_vld) begin
      o_rsp_data <= i_alu_res;
      o_rsp_id   <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  assign o_rsp_valid = (state_q == S_FULL);
  assign o_busy      = o_rsp_valid | (|i_req_valid);

`ifdef ALU_ARB_CNT_EN
  for (genvar k = 0; k < NREQ; k++) begin : g_cnt
    logic [15:0] cnt_q;
    // Saturating: a stuck-at-max counter is more useful for debug than a wrapped one.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                                       cnt_q <= '0;
      else if (grant_vld && grant_idx == IDW'(k) && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign o_grant_cnt[k*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational `alu` instance among NREQ requesters, e.g. the integer pipe, an address-generation unit and a debug/CSR path.
- Arbitrates round-robin over valid/ready request channels and steers the granted operands and opcode to the ALU.
- Registers the ALU result into a single response slot, tagged with the requester index.
- Sits between the requesters and the `alu` datapath; the ALU itself is unchanged.

Parameters:
- NREQ, 3, number of requesters (2..8).
- DW, 32, operand/result width.
- OPW, 4, ALU opcode width (matches ALUSel_e encoding).
- IDW, 2, response tag width; must satisfy 2^IDW >= NREQ.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  NREQ  per-requester request valid.
- o_req_ready  out  NREQ  per-requester accept; one-hot or zero.
- i_req_operand_a  in  NREQ*DW  packed operand A; requester k at bits [k*DW +: DW].
- i_req_operand_b  in  NREQ*DW  packed operand B.
- i_req_alu_op  in  NREQ*OPW  packed opcode.
- o_alu_operand_a  out  DW  to ALU.
- o_alu_operand_b  out  DW  to ALU.
- o_alu_op  out  OPW  to ALU.
- i_alu_res  in  DW  from ALU, combinational.
- o_rsp_valid  out  1  response slot full.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  DW  registered ALU result.
- o_rsp_id  out  IDW  index of the requester that produced o_rsp_data.
- o_busy  out  1  = o_rsp_valid | (|i_req_valid).

Behaviour:
- Reset (async, i_rst=1):
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0.
  - RR pointer last_grant=NREQ-1, so requester 0 has first priority.
  - State=S_EMPTY.
  - Any in-flight response is discarded.
  - o_req_ready=0 while i_rst is high.
- FSM states:
  - S_EMPTY: slot empty.
  - S_FULL: slot holds an unaccepted response.
- slot_free = (state==S_EMPTY) | (state==S_FULL & i_rsp_ready).
- Grant (combinational):
  - If slot_free and any i_req_valid, grant the first valid requester scanning last_grant+1, +2, … with wrap modulo NREQ.
  - o_req_ready = onehot(grant).
  - If there is no grant, o_req_ready=0.
- ALU steering:
  - When a grant is active, the o_alu_* outputs are the granted requester's operands and opcode.
  - Otherwise they are all-zero (opcode 0 = ADD), so the ALU inputs are quiet while idle.
- On a clock edge with a grant:
  - o_rsp_data <= i_alu_res.
  - o_rsp_id <= grant index.
  - last_grant <= grant index.
  - state <= S_FULL.
- On a clock edge with no grant and a response accepted (S_FULL & i_rsp_ready): state <= S_EMPTY; o_rsp_data and o_rsp_id hold their values.
- Simultaneous accept and grant in S_FULL: the slot is overwritten with the new result and state stays S_FULL. This gives 1 op/cycle throughput with i_rsp_ready held high.
- Latency: request accepted in cycle t -> o_rsp_valid high in cycle t+1.
- Backpressure: in S_FULL with i_rsp_ready=0, no grant; o_rsp_data and o_rsp_id are held stable.
- Protocol rules:
  - A requester keeps valid and its payload stable until ready.
  - A dropped valid before accept is legal and simply re-arbitrated, with no state change.
- Fairness: with all NREQ requesters continuously valid and i_rsp_ready=1, the grant sequence is 0,1,…,NREQ-1,0,… No requester waits more than NREQ-1 grants.
- Width: results are passed through unmodified; no arithmetic inside the block.

Optional Feature:
- Macro: ALU_ARB_CNT_EN.
- Defined: adds output o_grant_cnt [NREQ*16], one 16-bit counter per requester.
  - Counter k increments on each grant to requester k.
  - Counters saturate at 16'hFFFF (no wrap).
  - Cleared by i_rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: assert i_rst while o_rsp_valid=1 -> o_rsp_valid=0 immediately, with no clock edge needed. After release, sole requester 2 with ADD 5+7 -> o_req_ready=3'b100; next cycle o_rsp_data=12, o_rsp_id=2.
- Round-robin: all 3 requesters valid, i_rsp_ready=1 for 6 cycles -> o_rsp_id sequence 0,1,2,0,1,2. Req0 SUB 10-3 yields o_rsp_data=7 when o_rsp_id=0.
- Backpressure: i_rsp_ready=0 with req1 valid -> first grant, then o_req_ready=0 and o_rsp_data held for 4 cycles. Raise i_rsp_ready -> pending req1 granted in the same cycle and the slot is overwritten.
- Idle steering: no requests -> o_alu_operand_a=0, o_alu_operand_b=0, o_alu_op=0, o_busy=0.
- Valid drop: req0 valid for one cycle while the slot is blocked, then deasserted -> no grant to 0; the next grant goes to whichever requester is valid. The pointer is unchanged by the drop.
- ALU_ARB_CNT_EN: 70000 grants to req1 -> o_grant_cnt[31:16] saturates at 16'hFFFF; others remain 0.
